pipeline_stall_ctrl: RTL and testbench

Central sequencer for the RV32IM pipeline stage buffers. Produces the IF buffer enable (the fetch unit's `i_fetch_buff_en`), the ID and EX buffer enables, and the ID/EX flush strobes. Inputs are load-use hazards, multi-cycle mul/div occupancy, branch misprediction (fetch unit `o_branch_miss`) and debug halt/resume. Sits beside the fetch unit and hazard detection logic; it holds no datapath.

---
 rtl/pipeline_stall_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
`timescale 1ns/1ps
// Pipeline stage-buffer sequencer: enables/flushes for IF/ID/EX from hazard, mul/div and debug inputs.
// Optional STALL_PERF_CNT_EN macro adds saturating stall/flush performance counters.
module pipeline_stall_ctrl #(
  parameter int unsigned INIT_CYCLES     = 2,
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MD_TIMEOUT      = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_branch_miss,
  input  logic        i_load_use,
  input  logic        i_muldiv_start,
  input  logic        i_muldiv_done,
  input  logic        i_halt_req,
  input  logic        i_resume,
  output logic        o_fetch_buff_en,
  output logic        o_decode_buff_en,
  output logic        o_exec_buff_en,
  output logic        o_id_flush,
  output logic        o_ex_flush,
  output logic [2:0]  o_state,
  output logic        o_md_timeout
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_lu_stalls,
  output logic [31:0] o_perf_md_stalls,
  output logic [31:0] o_perf_flushes
`endif
);

  localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int unsigned LU_W   = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES) : 1;
  localparam int unsigned WD_W   = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [LU_W-1:0]   LU_LOAD   = LU_W'(LU_STALL_CYCLES - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(MD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    RUN      = 3'd1,
    LU_STALL = 3'd2,
    MD_WAIT  = 3'd3,
    HALT     = 3'd4
  } state_e;

  state_e            state;
  logic [INIT_W-1:0] init_cnt;
  logic [LU_W-1:0]   lu_cnt;
  logic [WD_W-1:0]   wd_cnt;

  assign o_state = state;

  always_comb begin
    o_fetch_buff_en  = 1'b0;
    o_decode_buff_en = 1'b0;
    o_exec_buff_en   = 1'b0;
    o_id_flush       = 1'b0;
    o_ex_flush       = 1'b0;
    o_md_timeout     = 1'b0;
    case (state)
      INIT: begin
        o_id_flush = 1'b1;
        o_ex_flush = 1'b1;
      end
      RUN, LU_STALL: begin
        o_fetch_buff_en  = 1'b1;
        o_decode_buff_en = 1'b1;
        o_exec_buff_en   = 1'b1;
        if (i_branch_miss) begin
          o_id_flush = 1'b1;
          o_ex_flush = 1'b1;
        end else if (state == LU_STALL || i_load_use) begin
          // Bubble: hold IF/ID, let EX advance with a flushed slot
          o_fetch_buff_en  = 1'b0;
          o_decode_buff_en = 1'b0;
          o_ex_flush       = 1'b1;
        end
      end
      MD_WAIT: begin
        if (i_muldiv_done) begin
          o_fetch_buff_en  = 1'b1;
          o_decode_buff_en = 1'b1;
          o_exec_buff_en   = 1'b1;
        end else if (wd_cnt == WD_LAST) begin
          o_md_timeout = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= INIT;
      init_cnt <= '0;
      lu_cnt   <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == INIT_LAST) state <= RUN;
          else                       init_cnt <= init_cnt + 1'b1;
        end
        RUN: begin
          if (i_branch_miss) begin
            state <= RUN;
          end else if (i_load_use) begin
            lu_cnt <= LU_LOAD;
            if (LU_LOAD != '0) state <= LU_STALL;
          end else if (i_muldiv_start) begin
            wd_cnt <= '0;
            if (!i_muldiv_done) state <= MD_WAIT;
          end else if (i_halt_req) begin
            state <= HALT;
          end
        end
        LU_STALL: begin
          if (i_branch_miss) begin
            lu_cnt <= '0;
            state  <= RUN;
          end else begin
            if (lu_cnt != '0) lu_cnt <= lu_cnt - 1'b1;
            if (lu_cnt <= LU_W'(1)) state <= RUN;
          end
        end
        MD_WAIT: begin
          if (i_muldiv_done || wd_cnt == WD_LAST) state <= RUN;
          else                                    wd_cnt <= wd_cnt + 1'b1;
        end
        HALT: begin
          if (i_resume) state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

  a_no_branch_miss_in_md_wait: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) (state == MD_WAIT) |-> !i_branch_miss
  );

`ifdef STALL_PERF_CNT_EN
  logic lu_bubble, md_cycle, flush_cycle;

  assign flush_cycle = (state == RUN || state == LU_STALL) && i_branch_miss;
  assign lu_bubble   = !i_branch_miss && ((state == RUN && i_load_use) || state == LU_STALL);
  assign md_cycle    = (state == MD_WAIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_lu_stalls <= '0;
      o_perf_md_stalls <= '0;
      o_perf_flushes   <= '0;
    end else begin
      if (lu_bubble && o_perf_lu_stalls != '1)  o_perf_lu_stalls <= o_perf_lu_stalls + 1'b1;
      if (md_cycle && o_perf_md_stalls != '1)   o_perf_md_stalls <= o_perf_md_stalls + 1'b1;
      if (flush_cycle && o_perf_flushes != '1)  o_perf_flushes   <= o_perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for pipeline_stall_ctrl: directed vector table, multi-cycle sequences,
// and randomized stimulus against a cycle-level reference model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned INIT_CYCLES     = 2;
  localparam int unsigned LU_STALL_CYCLES = 3;
  localparam int unsigned MD_TIMEOUT      = 64;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_branch_miss = 1'b0, i_load_use = 1'b0, i_muldiv_start = 1'b0;
  logic       i_muldiv_done = 1'b0, i_halt_req = 1'b0, i_resume = 1'b0;
  logic       o_fetch_buff_en, o_decode_buff_en, o_exec_buff_en;
  logic       o_id_flush, o_ex_flush, o_md_timeout;
  logic [2:0] o_state;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] o_perf_lu_stalls, o_perf_md_stalls, o_perf_flushes;
`endif

  int vectors = 0;
  int miscompares = 0;

  pipeline_stall_ctrl #(
    .INIT_CYCLES(INIT_CYCLES),
    .LU_STALL_CYCLES(LU_STALL_CYCLES),
    .MD_TIMEOUT(MD_TIMEOUT)
  ) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_branch_miss(i_branch_miss),
    .i_load_use(i_load_use),
    .i_muldiv_start(i_muldiv_start),
    .i_muldiv_done(i_muldiv_done),
    .i_halt_req(i_halt_req),
    .i_resume(i_resume),
    .o_fetch_buff_en(o_fetch_buff_en),
    .o_decode_buff_en(o_decode_buff_en),
    .o_exec_buff_en(o_exec_buff_en),
    .o_id_flush(o_id_flush),
    .o_ex_flush(o_ex_flush),
    .o_state(o_state),
    .o_md_timeout(o_md_timeout)
`ifdef STALL_PERF_CNT_EN
    ,
    .o_perf_lu_stalls(o_perf_lu_stalls),
    .o_perf_md_stalls(o_perf_md_stalls),
    .o_perf_flushes(o_perf_flushes)
`endif
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: bench did not finish (vectors=%0d)", vectors);
    $fatal(1);
  end

  // Expected control word: {fetch_en, decode_en, exec_en, id_flush, ex_flush, md_timeout}
  localparam logic [5:0] C_INIT  = 6'b000110;
  localparam logic [5:0] C_RUN   = 6'b111000;
  localparam logic [5:0] C_FLUSH = 6'b111110;
  localparam logic [5:0] C_LU    = 6'b001010;
  localparam logic [5:0] C_IDLE  = 6'b000000;
  localparam logic [5:0] C_TMO   = 6'b000001;

  typedef struct {
    string      name;
    logic [5:0] in;   // {branch_miss, load_use, muldiv_start, muldiv_done, halt_req, resume}
    logic [2:0] exp_state;
    logic [5:0] exp_ctl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [5:0] in, logic [2:0] s, logic [5:0] c);
    vec_t v;
    v.name = n; v.in = in; v.exp_state = s; v.exp_ctl = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] es, input logic [5:0] ec);
    logic [5:0] ac;
    ac = {o_fetch_buff_en, o_decode_buff_en, o_exec_buff_en, o_id_flush, o_ex_flush, o_md_timeout};
    vectors++;
    if (o_state !== es || ac !== ec) begin
      miscompares++;
      $display("FAIL %s @%0t: state=%0d ctl=%b, required state=%0d ctl=%b",
               name, $time, o_state, ac, es, ec);
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance one clock.
  task automatic step(input string name, input logic [5:0] in, input logic [2:0] es, input logic [5:0] ec);
    {i_branch_miss, i_load_use, i_muldiv_start, i_muldiv_done, i_halt_req, i_resume} = in;
    @(negedge i_clk);
    check(name, es, ec);
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: remaining init cycles, remaining bubbles, mul/div age, halted flag.
  int unsigned m_init_left, m_bubbles, m_md_age;
  bit          m_md_on, m_halted;

  task automatic model_reset();
    m_init_left = INIT_CYCLES;
    m_bubbles = 0; m_md_age = 0; m_md_on = 0; m_halted = 0;
  endtask

  task automatic model_cycle(input logic [5:0] in, output logic [2:0] es, output logic [5:0] ec);
    logic bm, lu, ms, md, hr, rs;
    {bm, lu, ms, md, hr, rs} = in;
    es = 3'd1; ec = C_RUN;
    if (m_init_left > 0) begin
      es = 3'd0; ec = C_INIT; m_init_left--;
    end else if (m_halted) begin
      es = 3'd4; ec = C_IDLE;
      if (rs) m_halted = 0;
    end else if (m_md_on) begin
      es = 3'd3; ec = C_IDLE;
      if (md) begin ec = C_RUN; m_md_on = 0; end
      else if (m_md_age == MD_TIMEOUT - 1) begin ec = C_TMO; m_md_on = 0; end
      else m_md_age++;
    end else if (m_bubbles > 0) begin
      es = 3'd2;
      if (bm) begin ec = C_FLUSH; m_bubbles = 0; end
      else begin ec = C_LU; m_bubbles--; end
    end else if (bm) begin
      ec = C_FLUSH;
    end else if (lu) begin
      ec = C_LU; m_bubbles = LU_STALL_CYCLES - 1;
    end else if (ms) begin
      if (!md) begin m_md_on = 1; m_md_age = 0; end
    end else if (hr) begin
      m_halted = 1;
    end
  endtask

  task automatic do_reset();
    {i_branch_miss, i_load_use, i_muldiv_start, i_muldiv_done, i_halt_req, i_resume} = '0;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("reset", 3'd0, C_INIT);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vecs.push_back(mk("init0",       6'b000000, 3'd0, C_INIT));
    vecs.push_back(mk("init1",       6'b000000, 3'd0, C_INIT));
    vecs.push_back(mk("run",         6'b000000, 3'd1, C_RUN));
    vecs.push_back(mk("lu_cycle",    6'b010000, 3'd1, C_LU));
    vecs.push_back(mk("lu_stall1",   6'b000000, 3'd2, C_LU));
    vecs.push_back(mk("lu_stall2",   6'b000000, 3'd2, C_LU));
    vecs.push_back(mk("lu_release",  6'b000000, 3'd1, C_RUN));
    vecs.push_back(mk("lu_again",    6'b010000, 3'd1, C_LU));
    vecs.push_back(mk("lu_stall1b",  6'b000000, 3'd2, C_LU));
    vecs.push_back(mk("lu_abort_bm", 6'b100000, 3'd2, C_FLUSH));
    vecs.push_back(mk("after_abort", 6'b000000, 3'd1, C_RUN));
    vecs.push_back(mk("bm_over_lu",  6'b110000, 3'd1, C_FLUSH));
    vecs.push_back(mk("still_run",   6'b000000, 3'd1, C_RUN));
    vecs.push_back(mk("md_zero",     6'b001100, 3'd1, C_RUN));
    vecs.push_back(mk("md_zero_run", 6'b000000, 3'd1, C_RUN));
    vecs.push_back(mk("md_start",    6'b001000, 3'd1, C_RUN));
    vecs.push_back(mk("md_wait1",    6'b000000, 3'd3, C_IDLE));
    vecs.push_back(mk("md_wait2",    6'b000000, 3'd3, C_IDLE));
    vecs.push_back(mk("md_done",     6'b000100, 3'd3, C_RUN));
    vecs.push_back(mk("md_back",     6'b000000, 3'd1, C_RUN));
    vecs.push_back(mk("halt_bm",     6'b100010, 3'd1, C_FLUSH));
    vecs.push_back(mk("halt_drain",  6'b000010, 3'd1, C_RUN));
    vecs.push_back(mk("halted",      6'b000010, 3'd4, C_IDLE));
    vecs.push_back(mk("resume_hold", 6'b000011, 3'd4, C_IDLE));
    vecs.push_back(mk("one_run",     6'b000010, 3'd1, C_RUN));
    vecs.push_back(mk("halt_bm_ign", 6'b100000, 3'd4, C_IDLE));
    vecs.push_back(mk("resume",      6'b000001, 3'd4, C_IDLE));
    vecs.push_back(mk("resumed",     6'b000000, 3'd1, C_RUN));

    do_reset();
    foreach (vecs[i]) step(vecs[i].name, vecs[i].in, vecs[i].exp_state, vecs[i].exp_ctl);

    // mul/div completing after 10 wait cycles
    step("md10_start", 6'b001000, 3'd1, C_RUN);
    for (int i = 0; i < 10; i++) step("md10_wait", 6'b000000, 3'd3, C_IDLE);
    step("md10_done", 6'b000100, 3'd3, C_RUN);
    step("md10_run", 6'b000000, 3'd1, C_RUN);

    // mul/div watchdog: pulse on the 64th cycle after start
    step("tmo_start", 6'b001000, 3'd1, C_RUN);
    for (int i = 0; i < MD_TIMEOUT - 1; i++) step("tmo_wait", 6'b000000, 3'd3, C_IDLE);
    step("tmo_pulse", 6'b000000, 3'd3, C_TMO);
    step("tmo_run", 6'b000000, 3'd1, C_RUN);

    // asynchronous reset while halted
    step("h_drain", 6'b000010, 3'd1, C_RUN);
    step("h_halted", 6'b000010, 3'd4, C_IDLE);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_async", 3'd0, C_INIT);
    {i_branch_miss, i_load_use, i_muldiv_start, i_muldiv_done, i_halt_req, i_resume} = '0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    step("rst_init0", 6'b000000, 3'd0, C_INIT);
    step("rst_init1", 6'b000000, 3'd0, C_INIT);
    step("rst_run", 6'b000000, 3'd1, C_RUN);

    // randomized stimulus against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [5:0] in;
      logic [2:0] es;
      logic [5:0] ec;
      if ($urandom_range(0, 599) == 0) do_reset();
      in[5] = ($urandom_range(0, 7) == 0);
      in[4] = ($urandom_range(0, 5) == 0);
      in[3] = ($urandom_range(0, 7) == 0);
      in[2] = m_md_on ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      in[1] = ($urandom_range(0, 15) == 0) || (m_halted && $urandom_range(0, 3) == 0);
      in[0] = ($urandom_range(0, 7) == 0);
      if (m_md_on && m_init_left == 0 && !m_halted) in[5] = 1'b0;
      model_cycle(in, es, ec);
      step("random", in, es, ec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
